// File: rtl/pixel_layer_arbiter_pkg.sv
// draw_pkg: FSM state encoding, screen bounds and colour constants shared by the layer arbiter
package draw_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SELECT = 2'd1, ST_DRAW = 2'd2, ST_FINISH = 2'd3} arb_state_e;
  localparam int unsigned SCREEN_W = 320;
  localparam int unsigned SCREEN_H = 240;
  localparam logic [11:0] COLOR_BLACK = 12'h000;
endpackage

// File: rtl/pixel_layer_arbiter_if.sv
// pixel_layer_arbiter_if: frame control, per-layer drawer bus and VGA pixel port of the layer arbiter
interface pixel_layer_arbiter_if #(
  parameter int N_LAYERS = 6,
  parameter int XW = 9,
  parameter int YW = 8,
  parameter int CW = 12
);
  localparam int IW = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1;
  logic frame_start;
  logic [N_LAYERS-1:0] layer_en;
  logic [N_LAYERS-1:0] layer_enable;
  logic [N_LAYERS*XW-1:0] layer_x;
  logic [N_LAYERS*YW-1:0] layer_y;
  logic [N_LAYERS*CW-1:0] layer_color;
  logic [N_LAYERS-1:0] layer_we;
  logic [N_LAYERS-1:0] layer_done;
  logic [XW-1:0] X_out;
  logic [YW-1:0] Y_out;
  logic [CW-1:0] Color_out;
  logic writeEn;
  logic busy;
  logic frame_done;
  logic [IW-1:0] active_layer;
  modport slave (
    input frame_start, layer_en, layer_x, layer_y, layer_color, layer_we, layer_done,
    output layer_enable, X_out, Y_out, Color_out, writeEn, busy, frame_done, active_layer
  );
  modport master (
    output frame_start, layer_en, layer_x, layer_y, layer_color, layer_we, layer_done,
    input layer_enable, X_out, Y_out, Color_out, writeEn, busy, frame_done, active_layer
  );
endinterface

// File: rtl/pixel_layer_select.sv
// pixel_layer_select: finds the lowest enabled layer at or above a start index
module pixel_layer_select #(
  parameter int N = 6,
  parameter int IW = 3
) (
  input  logic [N-1:0]  en_i,
  input  logic [IW-1:0] start_i,
  output logic          found_o,
  output logic [IW-1:0] sel_o
);
  // Scan from the top down so the lowest qualifying index is the last to win
  always_comb begin
    found_o = 1'b0;
    sel_o = start_i;
    for (int i = N - 1; i >= 0; i--)
      if (en_i[i] && IW'(i) >= start_i) begin
        found_o = 1'b1;
        sel_o = IW'(i);
      end
  end
endmodule

// File: rtl/pixel_layer_arbiter.sv
// pixel_layer_arbiter: draws enabled layers bottom-up and muxes their pixels to one VGA write port; define PIXEL_ARB_CLIP_EN to drop off-screen pixels
module pixel_layer_arbiter
  import draw_pkg::*;
#(
  parameter int N_LAYERS = 6,
  parameter int XW = 9,
  parameter int YW = 8,
  parameter int CW = 12,
  parameter logic [CW-1:0] TRANSP_KEY = CW'(COLOR_BLACK),
  parameter logic [N_LAYERS-1:0] TRANSP_MASK = {{(N_LAYERS-1){1'b1}}, 1'b0}
) (
  input logic clk,
  input logic resetn,
  pixel_layer_arbiter_if.slave bus
);
  localparam int IW = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1;
  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] SELECT = ST_SELECT;
  localparam logic [1:0] DRAW = ST_DRAW;
  localparam logic [1:0] FINISH = ST_FINISH;
  logic [1:0] state_q, state_d;
  logic [IW-1:0] idx_q, idx_d, sel;
  logic [N_LAYERS-1:0] en_q, en_d;
  logic found, last, done_sel, we_sel, wr_d, wr_q;
  logic [XW-1:0] x_sel, x_q;
  logic [YW-1:0] y_sel, y_q;
  logic [CW-1:0] c_sel, c_q;
  pixel_layer_select #(.N(N_LAYERS), .IW(IW)) u_select (
    .en_i(en_q),
    .start_i(idx_q),
    .found_o(found),
    .sel_o(sel)
  );
  assign last = idx_q == IW'(N_LAYERS - 1);
  assign x_sel = bus.layer_x[idx_q*XW +: XW];
  assign y_sel = bus.layer_y[idx_q*YW +: YW];
  assign c_sel = bus.layer_color[idx_q*CW +: CW];
  assign we_sel = bus.layer_we[idx_q];
  assign done_sel = bus.layer_done[idx_q];
  assign wr_d = we_sel && !(TRANSP_MASK[idx_q] && c_sel == TRANSP_KEY)
`ifdef PIXEL_ARB_CLIP_EN
    && (32'(x_sel) < SCREEN_W) && (32'(y_sel) < SCREEN_H)
`endif
    ;
  // Frame sequencing: latch the mask on start, then alternate SELECT/DRAW per enabled layer
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    en_d = en_q;
    case (state_q)
      IDLE: if (bus.frame_start) begin
        state_d = SELECT;
        idx_d = '0;
        en_d = bus.layer_en;
      end
      SELECT: begin
        state_d = found ? DRAW : FINISH;
        idx_d = found ? sel : idx_q;
      end
      DRAW: if (done_sel) begin
        state_d = last ? FINISH : SELECT;
        idx_d = last ? idx_q : idx_q + IW'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  // State, layer cursor and frame-latched enable mask
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      idx_q <= '0;
      en_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      en_q <= en_d;
    end
  end
  // Pixel register follows the selected layer while drawing and holds otherwise
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x_q <= '0;
      y_q <= '0;
      c_q <= '0;
      wr_q <= 1'b0;
    end else if (state_q == DRAW) begin
      x_q <= x_sel;
      y_q <= y_sel;
      c_q <= c_sel;
      wr_q <= wr_d;
    end else begin
      wr_q <= 1'b0;
    end
  end
  assign bus.layer_enable = (state_q == DRAW) ? {{(N_LAYERS-1){1'b0}}, 1'b1} << idx_q : '0;
  assign bus.X_out = x_q;
  assign bus.Y_out = y_q;
  assign bus.Color_out = c_q;
  assign bus.writeEn = wr_q;
  assign bus.busy = state_q == SELECT || state_q == DRAW;
  assign bus.frame_done = state_q == FINISH;
  assign bus.active_layer = idx_q;
endmodule

// File: tb/tb_pixel_layer_arbiter.sv
// tb_pixel_layer_arbiter: directed scenarios for pixel_layer_arbiter with modelled layer drawers
module tb_pixel_layer_arbiter;
`ifdef PIXEL_ARB_CLIP_EN
  localparam bit CLIP_ON = 1'b1;
`else
  localparam bit CLIP_ON = 1'b0;
`endif
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int passed = 0;
  int total = 0;
  int we_cnt, done_cnt, seq, pix_err, sel_err, done_cyc;
  bit busy_first, busy_at_done, aborted;
  pixel_layer_arbiter_if #(.N_LAYERS(6), .XW(9), .YW(8), .CW(12)) bus ();
  pixel_layer_arbiter #(.N_LAYERS(6), .XW(9), .YW(8), .CW(12)) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus)
  );
  always #5 clk = ~clk;
  function automatic logic [8:0] px(input int l, input int k, input logic [5:0] bx);
    return bx[l] ? 9'd330 : 9'(l * 16 + k + 1);
  endfunction
  function automatic logic [7:0] py(input int l, input int k);
    return 8'(l * 8 + k + 1);
  endfunction
  function automatic logic [11:0] pc(input int l, input int k, input logic [5:0] zc);
    return zc[l] ? 12'h000 : 12'(12'h100 * (l + 1) + k + 1);
  endfunction
  function automatic logic exp_wr(input int l, input logic [11:0] c, input logic [8:0] x);
    return !(l != 0 && c == 12'h000) && !(CLIP_ON && x >= 9'd320);
  endfunction
  task automatic drive_idle(input bit g);
    for (int i = 0; i < 6; i++) begin
      bus.layer_x[i*9 +: 9] = 9'($urandom);
      bus.layer_y[i*8 +: 8] = 8'($urandom);
      bus.layer_color[i*12 +: 12] = 12'h000;
      bus.layer_we[i] = g;
      bus.layer_done[i] = g;
    end
  endtask
  task automatic run_frame(input logic [5:0] en, input logic [5:0] zc, input logic [5:0] bx, input bit mid_fs, input int abort_l);
    int cnt[6];
    int l;
    bit fin;
    logic ew;
    logic [8:0] ex;
    logic [7:0] ey;
    logic [11:0] ec;
    we_cnt = 0; done_cnt = 0; seq = 0; pix_err = 0; sel_err = 0; done_cyc = -1;
    busy_first = 1'b0; busy_at_done = 1'b1; aborted = 1'b0; fin = 1'b0;
    ew = 1'b0; ex = '0; ey = '0; ec = '0;
    foreach (cnt[i]) cnt[i] = 0;
    @(negedge clk);
    bus.frame_start = 1'b1;
    bus.layer_en = en;
    drive_idle(1'b1);
    for (int cyc = 1; cyc < 200 && !fin; cyc++) begin
      @(negedge clk);
      if (cyc == 1) busy_first = bus.busy;
      if (bus.writeEn !== ew) pix_err++;
      else if (ew && (bus.X_out !== ex || bus.Y_out !== ey || bus.Color_out !== ec)) pix_err++;
      if (bus.writeEn === 1'b1) we_cnt++;
      l = -1;
      for (int i = 0; i < 6; i++) if (bus.layer_enable[i] === 1'b1) l = i;
      if (!$onehot0(bus.layer_enable) || (l >= 0 && bus.active_layer !== 3'(l))) sel_err++;
      if (l >= 0 && cnt[l] == 0) seq = seq * 10 + l + 1;
      if (bus.frame_done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
        busy_at_done = bus.busy;
        fin = 1'b1;
      end
      if (abort_l >= 0 && l == abort_l) begin
        aborted = 1'b1;
        fin = 1'b1;
      end
      bus.frame_start = mid_fs && l >= 0 && cnt[l] == 1;
      bus.layer_en = ~en;
      drive_idle(1'b1);
      ew = 1'b0;
      if (l >= 0) begin
        bus.layer_x[l*9 +: 9] = px(l, cnt[l], bx);
        bus.layer_y[l*8 +: 8] = py(l, cnt[l]);
        bus.layer_color[l*12 +: 12] = pc(l, cnt[l], zc);
        bus.layer_done[l] = cnt[l] == 3;
        ew = exp_wr(l, pc(l, cnt[l], zc), px(l, cnt[l], bx));
        ex = px(l, cnt[l], bx);
        ey = py(l, cnt[l]);
        ec = pc(l, cnt[l], zc);
        cnt[l]++;
      end
    end
    if (!aborted) begin
      bus.frame_start = 1'b0;
      drive_idle(1'b0);
      repeat (4) begin
        @(negedge clk);
        if (bus.frame_done === 1'b1) done_cnt++;
        if (bus.writeEn === 1'b1) we_cnt++;
      end
    end
  endtask
  task automatic test_reset;
    bus.frame_start = 1'b0;
    bus.layer_en = '0;
    drive_idle(1'b0);
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({bus.X_out, bus.Y_out, bus.Color_out} !== 29'd0) $display("FAIL reset_pixel: got %h expected 0", {bus.X_out, bus.Y_out, bus.Color_out});
    else passed++;
    total++;
    if ({bus.writeEn, bus.busy, bus.frame_done} !== 3'b000) $display("FAIL reset_flags: got %b expected 000", {bus.writeEn, bus.busy, bus.frame_done});
    else passed++;
    total++;
    if ({bus.layer_enable, bus.active_layer} !== 9'd0) $display("FAIL reset_enable: got %h expected 0", {bus.layer_enable, bus.active_layer});
    else passed++;
    resetn = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_all_layers;
    run_frame(6'b111111, 6'b000000, 6'b000000, 1'b0, -1);
    total++;
    if (seq !== 123456) $display("FAIL all_order: got %0d expected 123456", seq);
    else passed++;
    total++;
    if (we_cnt !== 24) $display("FAIL all_writes: got %0d expected 24", we_cnt);
    else passed++;
    total++;
    if (done_cnt !== 1) $display("FAIL all_done: got %0d expected 1", done_cnt);
    else passed++;
    total++;
    if (pix_err !== 0) $display("FAIL all_pixels: got %0d errors expected 0", pix_err);
    else passed++;
    total++;
    if (sel_err !== 0) $display("FAIL all_select: got %0d errors expected 0", sel_err);
    else passed++;
    total++;
    if ({busy_first, busy_at_done} !== 2'b10) $display("FAIL all_busy: got %b expected 10", {busy_first, busy_at_done});
    else passed++;
  endtask
  task automatic test_sparse;
    run_frame(6'b100101, 6'b000000, 6'b000000, 1'b0, -1);
    total++;
    if (seq !== 136) $display("FAIL sparse_order: got %0d expected 136", seq);
    else passed++;
    total++;
    if (we_cnt !== 12) $display("FAIL sparse_writes: got %0d expected 12", we_cnt);
    else passed++;
    total++;
    if (done_cnt !== 1) $display("FAIL sparse_done: got %0d expected 1", done_cnt);
    else passed++;
    total++;
    if (pix_err + sel_err !== 0) $display("FAIL sparse_pixels: got %0d errors expected 0", pix_err + sel_err);
    else passed++;
  endtask
  task automatic test_empty;
    run_frame(6'b000000, 6'b000000, 6'b000000, 1'b0, -1);
    total++;
    if (done_cyc !== 2) $display("FAIL empty_latency: got %0d expected 2", done_cyc);
    else passed++;
    total++;
    if (seq !== 0) $display("FAIL empty_enable: got %0d expected 0", seq);
    else passed++;
    total++;
    if (done_cnt !== 1) $display("FAIL empty_done: got %0d expected 1", done_cnt);
    else passed++;
    total++;
    if (we_cnt !== 0) $display("FAIL empty_writes: got %0d expected 0", we_cnt);
    else passed++;
  endtask
  task automatic test_transparency;
    run_frame(6'b000101, 6'b000101, 6'b000000, 1'b0, -1);
    total++;
    if (we_cnt !== 4) $display("FAIL transp_writes: got %0d expected 4", we_cnt);
    else passed++;
    total++;
    if (pix_err !== 0) $display("FAIL transp_pixels: got %0d errors expected 0", pix_err);
    else passed++;
    total++;
    if (seq !== 13) $display("FAIL transp_order: got %0d expected 13", seq);
    else passed++;
  endtask
  task automatic test_back_to_back;
    run_frame(6'b000011, 6'b000000, 6'b000000, 1'b1, -1);
    total++;
    if (done_cnt !== 1) $display("FAIL midstart_done: got %0d expected 1", done_cnt);
    else passed++;
    total++;
    if (seq !== 12) $display("FAIL midstart_order: got %0d expected 12", seq);
    else passed++;
    total++;
    if (we_cnt !== 8) $display("FAIL midstart_writes: got %0d expected 8", we_cnt);
    else passed++;
  endtask
  task automatic test_clip;
    run_frame(6'b000001, 6'b000000, 6'b000001, 1'b0, -1);
    total++;
    if (we_cnt !== (CLIP_ON ? 0 : 4)) $display("FAIL clip_writes: got %0d expected %0d", we_cnt, CLIP_ON ? 0 : 4);
    else passed++;
    total++;
    if (pix_err !== 0) $display("FAIL clip_pixels: got %0d errors expected 0", pix_err);
    else passed++;
  endtask
  task automatic test_reset_mid;
    run_frame(6'b111111, 6'b000000, 6'b000000, 1'b0, 3);
    total++;
    if (aborted !== 1'b1) $display("FAIL rstmid_reach: got %0d expected 1", aborted);
    else passed++;
    #2 resetn = 1'b0;
    #1;
    total++;
    if ({bus.layer_enable, bus.active_layer, bus.writeEn, bus.busy, bus.frame_done} !== 12'd0)
      $display("FAIL rstmid_ctrl: got %h expected 0", {bus.layer_enable, bus.active_layer, bus.writeEn, bus.busy, bus.frame_done});
    else passed++;
    total++;
    if ({bus.X_out, bus.Y_out, bus.Color_out} !== 29'd0) $display("FAIL rstmid_pixel: got %h expected 0", {bus.X_out, bus.Y_out, bus.Color_out});
    else passed++;
    bus.frame_start = 1'b0;
    drive_idle(1'b0);
    @(negedge clk);
    total++;
    if (bus.frame_done !== 1'b0) $display("FAIL rstmid_nodone: got %b expected 0", bus.frame_done);
    else passed++;
    resetn = 1'b1;
    run_frame(6'b111111, 6'b000000, 6'b000000, 1'b0, -1);
    total++;
    if (seq !== 123456) $display("FAIL rstmid_restart: got %0d expected 123456", seq);
    else passed++;
    total++;
    if (done_cnt !== 1) $display("FAIL rstmid_done: got %0d expected 1", done_cnt);
    else passed++;
  endtask
  initial begin
    test_reset;
    test_all_layers;
    test_sparse;
    test_empty;
    test_transparency;
    test_back_to_back;
    test_clip;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
